// File: rtl/led_flow_if.sv
// led_flow_if: step input and LED drive bundle for led_flow_ctrl.
// Ports: led_in/en/mode into the block, led_out/step_pulse out of it.
interface led_flow_if #(
    parameter int LED_W = 4
);
    logic             led_in;
    logic             en;
    logic [1:0]       mode;
    logic [LED_W-1:0] led_out;
    logic             step_pulse;

    modport master (
        output led_in, en, mode,
        input  led_out, step_pulse
    );

    modport slave (
        input  led_in, en, mode,
        output led_out, step_pulse
    );
endinterface

// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: advances an LED pattern on each led_in level change.
// Ports: sys_clk, sys_rst_n (async low), bus = led_flow_if.slave.
module led_flow_ctrl #(
    parameter int LED_W       = 4,
    parameter bit LED_ACT_LOW = 1'b1
) (
    input  logic      sys_clk,
    input  logic      sys_rst_n,
    led_flow_if.slave bus
);
    typedef enum logic [1:0] {
        ROT_L    = 2'b00,
        ROT_R    = 2'b01,
        PINGPONG = 2'b10,
        BLINK    = 2'b11
    } mode_t;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_t;

    localparam logic [LED_W-1:0] PAT_ONE = LED_W'(1);
    localparam logic [LED_W-1:0] PAT_ALL = '1;

    logic             led_in_d1;
    logic             step;
    logic             accept;
    logic             one_hot;
    logic             step_pulse_q;
    logic [LED_W-1:0] pat;
    logic [LED_W-1:0] pat_nxt;
    dir_t             dir;
    dir_t             dir_nxt;
    mode_t            mode;

    assign mode   = mode_t'(bus.mode);
    assign step   = bus.led_in ^ led_in_d1;
    assign accept = step & bus.en;
    // Single set bit: non-zero and clearing the lowest set bit leaves zero.
    assign one_hot = (pat != '0) && ((pat & (pat - PAT_ONE)) == '0);

    // State register. led_in_d1 tracks regardless of en so that
    // re-enabling never sees a stale edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_in_d1    <= 1'b0;
            pat          <= PAT_ONE;
            dir          <= UP;
            step_pulse_q <= 1'b0;
        end else begin
            led_in_d1    <= bus.led_in;
            pat          <= pat_nxt;
            dir          <= dir_nxt;
            step_pulse_q <= accept;
        end
    end

    // Next-state logic, evaluated only on an accepted step.
    always_comb begin
        pat_nxt = pat;
        dir_nxt = dir;
        if (accept) begin
            unique case (mode)
                ROT_L: begin
                    if (!one_hot) begin
                        pat_nxt = PAT_ONE;
                        dir_nxt = UP;
                    end else begin
                        pat_nxt = {pat[LED_W-2:0], pat[LED_W-1]};
                    end
                end
                ROT_R: begin
                    if (!one_hot) begin
                        pat_nxt = PAT_ONE;
                        dir_nxt = UP;
                    end else begin
                        pat_nxt = {pat[0], pat[LED_W-1:1]};
                    end
                end
                PINGPONG: begin
                    if (!one_hot) begin
                        pat_nxt = PAT_ONE;
                        dir_nxt = UP;
                    end else if (dir == UP) begin
                        // Bounce off the top without dwelling on it.
                        if (pat[LED_W-1]) begin
                            pat_nxt = pat >> 1;
                            dir_nxt = DN;
                        end else begin
                            pat_nxt = pat << 1;
                        end
                    end else begin
                        if (pat[0]) begin
                            pat_nxt = pat << 1;
                            dir_nxt = UP;
                        end else begin
                            pat_nxt = pat >> 1;
                        end
                    end
                end
                BLINK: begin
                    pat_nxt = (pat == PAT_ALL) ? '0 : PAT_ALL;
                    dir_nxt = UP;
                end
            endcase
        end
    end

    // Outputs depend on registers only.
    always_comb begin
        bus.led_out    = LED_ACT_LOW ? ~pat : pat;
        bus.step_pulse = step_pulse_q;
    end
endmodule

// File: tb/tb_led_flow_ctrl.sv
// tb_led_flow_ctrl: directed table, corner sequences and random
// stimulus against a position-based reference model.
module tb_led_flow_ctrl;
    localparam int W = 4;
    localparam logic [W-1:0] FULL = '1;

    typedef struct {
        bit         led;
        bit         en;
        logic [1:0] mode;
        logic [W-1:0] pat;
        bit         pulse;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    led_flow_if #(.LED_W(W)) bus();

    led_flow_ctrl #(.LED_W(W), .LED_ACT_LOW(1'b1)) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: pattern, direction, last sampled led_in.
    logic [W-1:0] m_pat;
    bit           m_up;
    bit           m_prev;
    bit           m_pulse;

    function automatic logic [W:0] exp_out(logic [W-1:0] p, bit pl);
        return {~p, pl};
    endfunction

    // Works on the lit position index rather than bit shifts.
    task automatic ref_next(input logic [1:0] md);
        int pos;
        pos = 0;
        if (md == 2'b11) begin
            m_pat = (m_pat == FULL) ? '0 : FULL;
            m_up  = 1;
        end else if ($countones(m_pat) != 1) begin
            m_pat = 1;
            m_up  = 1;
        end else begin
            for (int i = 0; i < W; i++)
                if (m_pat[i]) pos = i;
            case (md)
                2'b00: pos = (pos + 1) % W;
                2'b01: pos = (pos + W - 1) % W;
                default: begin
                    if (m_up) begin
                        if (pos == W - 1) begin
                            m_up = 0;
                            pos  = pos - 1;
                        end else pos = pos + 1;
                    end else begin
                        if (pos == 0) begin
                            m_up = 1;
                            pos  = pos + 1;
                        end else pos = pos - 1;
                    end
                end
            endcase
            m_pat = W'(1) << pos;
        end
    endtask

    task automatic chk(input string nm, input logic [W:0] act,
                       input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, optional async reset pulse
    // before the edge, update model at posedge, return at negedge.
    task automatic cyc(input bit led, input bit e,
                       input logic [1:0] md, input bit rst);
        bit st;
        bus.led_in = led;
        bus.en     = e;
        bus.mode   = md;
        if (rst) begin
            #2 rst_n = 1'b0;
            #1 chk("async_rst", {bus.led_out, bus.step_pulse},
                   exp_out(W'(1), 1'b0));
            m_pat = 1; m_up = 1; m_prev = 0; m_pulse = 0;
            #1 rst_n = 1'b1;
        end
        @(posedge clk);
        st      = (led != m_prev);
        m_prev  = led;
        m_pulse = st && e;
        if (m_pulse) ref_next(md);
        @(negedge clk);
    endtask

    vec_t tbl[$];

    function automatic vec_t mk(bit l, bit e, logic [1:0] md,
                                logic [W-1:0] p, bit pl);
        vec_t v;
        v.led = l; v.en = e; v.mode = md; v.pat = p; v.pulse = pl;
        return v;
    endfunction

    initial begin
        bit led;
        // rotate left, 5 toggles plus a hold
        tbl.push_back(mk(1, 1, 2'b00, 4'b0010, 1));
        tbl.push_back(mk(1, 1, 2'b00, 4'b0010, 0));
        tbl.push_back(mk(0, 1, 2'b00, 4'b0100, 1));
        tbl.push_back(mk(1, 1, 2'b00, 4'b1000, 1));
        tbl.push_back(mk(0, 1, 2'b00, 4'b0001, 1));
        tbl.push_back(mk(1, 1, 2'b00, 4'b0010, 1));
        // rotate right back to 0001, then ping-pong 8 toggles
        tbl.push_back(mk(0, 1, 2'b01, 4'b0001, 1));
        tbl.push_back(mk(1, 1, 2'b10, 4'b0010, 1));
        tbl.push_back(mk(0, 1, 2'b10, 4'b0100, 1));
        tbl.push_back(mk(1, 1, 2'b10, 4'b1000, 1));
        tbl.push_back(mk(0, 1, 2'b10, 4'b0100, 1));
        tbl.push_back(mk(1, 1, 2'b10, 4'b0010, 1));
        tbl.push_back(mk(0, 1, 2'b10, 4'b0001, 1));
        tbl.push_back(mk(1, 1, 2'b10, 4'b0010, 1));
        tbl.push_back(mk(0, 1, 2'b10, 4'b0100, 1));
        tbl.push_back(mk(0, 1, 2'b10, 4'b0100, 0));
        // blink 3 toggles, then rotate right with recovery
        tbl.push_back(mk(1, 1, 2'b11, 4'b1111, 1));
        tbl.push_back(mk(0, 1, 2'b11, 4'b0000, 1));
        tbl.push_back(mk(1, 1, 2'b11, 4'b1111, 1));
        tbl.push_back(mk(0, 1, 2'b01, 4'b0001, 1));
        tbl.push_back(mk(1, 1, 2'b01, 4'b1000, 1));
        // en=0 over 3 toggles, re-enable mid-interval
        tbl.push_back(mk(0, 0, 2'b01, 4'b1000, 0));
        tbl.push_back(mk(1, 0, 2'b01, 4'b1000, 0));
        tbl.push_back(mk(0, 0, 2'b01, 4'b1000, 0));
        tbl.push_back(mk(0, 1, 2'b01, 4'b1000, 0));
        tbl.push_back(mk(0, 1, 2'b01, 4'b1000, 0));
        tbl.push_back(mk(1, 1, 2'b01, 4'b0100, 1));

        bus.led_in = 0; bus.en = 0; bus.mode = 2'b00;
        m_pat = 1; m_up = 1; m_prev = 0; m_pulse = 0;

        @(negedge clk);
        #2 chk("reset_state", {bus.led_out, bus.step_pulse},
               exp_out(4'b0001, 0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 2'b00, 0);
        chk("no_step_at_release", {bus.led_out, bus.step_pulse},
            exp_out(4'b0001, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].led, tbl[i].en, tbl[i].mode, 0);
            chk($sformatf("tbl[%0d]", i), {bus.led_out, bus.step_pulse},
                exp_out(tbl[i].pat, tbl[i].pulse));
        end

        // ping-pong to 0100 going down, then async reset
        cyc(0, 1, 2'b10, 0);
        chk("pp_top", {bus.led_out, bus.step_pulse},
            exp_out(4'b1000, 1));
        cyc(1, 1, 2'b10, 0);
        chk("pp_dn", {bus.led_out, bus.step_pulse},
            exp_out(4'b0100, 1));
        cyc(0, 1, 2'b10, 1);
        chk("post_rst_idle", {bus.led_out, bus.step_pulse},
            exp_out(4'b0001, 0));
        cyc(1, 1, 2'b10, 0);
        chk("post_rst_up", {bus.led_out, bus.step_pulse},
            exp_out(4'b0010, 1));

        // led_in high at reset release gives exactly one step
        cyc(1, 1, 2'b00, 1);
        chk("high_at_release", {bus.led_out, bus.step_pulse},
            exp_out(4'b0010, 1));
        cyc(1, 1, 2'b00, 0);
        chk("high_hold", {bus.led_out, bus.step_pulse},
            exp_out(4'b0010, 0));

        // random phase against the reference model
        led = 1;
        for (int n = 0; n < 3000; n++) begin
            bit e, r;
            logic [1:0] md;
            if ($urandom_range(0, 3) == 0) led = ~led;
            e  = ($urandom_range(0, 7) != 0);
            md = 2'($urandom_range(0, 3));
            r  = ($urandom_range(0, 199) == 0);
            cyc(led, e, md, r);
            chk("rand", {bus.led_out, bus.step_pulse},
                exp_out(m_pat, m_pulse));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
